// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared constants for the counter bank.
//   Channel modes, channel FSM state encoding, config address map and
//   the bit layout of the CTRL register ({mode[1:0], dir, en}).
package counter_bank_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_CMP    = 2'd2;
  localparam logic [1:0] A_PRESC  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_MODE_LO = 2;

endpackage

// File: rtl/counter_bank_ch.sv
// counter_bank_ch: one counter channel of the bank.
//   Holds its own CTRL/RELOAD/CMP registers, the IDLE/RUN/DONE FSM and the
//   count, and produces registered tc/match (and optionally pwm) pulses.
// Ports:
//   clk, rst          clock, async active-high reset
//   tick_i            shared prescaler tick
//   wr_ctrl_i         CTRL write addressed to this channel
//   wr_reload_i       RELOAD write addressed to this channel
//   wr_cmp_i          CMP write addressed to this channel
//   wdata_i           config write data
//   count_o           current count
//   busy_o            channel in RUN
//   tc_o, match_o     one-clock terminal-count / compare-match pulses
//   pwm_o             busy && count < CMP, registered (COUNTER_BANK_PWM_EN only)
// Build option: COUNTER_BANK_PWM_EN enables the PWM compare; otherwise pwm_o = 0.
import counter_bank_pkg::*;

module counter_bank_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_reload_i,
  input  logic             wr_cmp_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             match_o,
  output logic             pwm_o
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             tc_q, tc_d;
  logic             match_q, match_d;

  logic             up;
  logic [1:0]       mode;
  logic [WIDTH-1:0] start_val, term_val;
  logic             at_term, wr_any;

  assign up        = ~ctrl_q[CTRL_DIR];
  assign mode      = ctrl_q[CTRL_MODE_LO +: 2];
  assign start_val = up ? '0 : reload_q;
  assign term_val  = up ? reload_q : '0;
  // Up counting treats count >= RELOAD as terminal, so lowering RELOAD
  // below the running count still keeps the count bounded.
  assign at_term   = up ? (count_q >= reload_q) : (count_q == '0);
  assign wr_any    = wr_ctrl_i | wr_reload_i | wr_cmp_i;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    tc_d     = 1'b0;
    match_d  = 1'b0;

    if (wr_reload_i) reload_d = wdata_i;
    if (wr_cmp_i)    cmp_d    = wdata_i;

    if (wr_ctrl_i) begin
      ctrl_d = wdata_i[3:0];
      if (wdata_i[CTRL_EN]) begin
        state_d = ST_RUN;
        count_d = wdata_i[CTRL_DIR] ? reload_q : '0;
        // Start value equals terminal value only when RELOAD is zero.
        tc_d    = (reload_q == '0);
        match_d = (count_d == cmp_q);
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick_i && !wr_any && state_q == ST_RUN && ctrl_q[CTRL_EN]) begin
      if (at_term) begin
        case (mode)
          MODE_SAT: count_d = term_val;
          MODE_ONESHOT: begin
            state_d         = ST_DONE;
            ctrl_d[CTRL_EN] = 1'b0;
          end
          default: begin
            count_d = start_val;
            tc_d    = (start_val == term_val);
          end
        endcase
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        tc_d    = (count_d == term_val);
      end
      match_d = (count_d == cmp_q) && (count_d != count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      cmp_q    <= '0;
      ctrl_q   <= '0;
      tc_q     <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      tc_q     <= tc_d;
      match_q  <= match_d;
    end
  end

`ifdef COUNTER_BANK_PWM_EN
  logic pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= (state_d == ST_RUN) && (count_d < cmp_d);
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

  assign count_o = count_q;
  assign busy_o  = (state_q == ST_RUN);
  assign tc_o    = tc_q;
  assign match_o = match_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: NCH independent WIDTH-bit counters sharing one prescaler.
//   The top holds the prescaler and the config address decode; each channel
//   is a counter_bank_ch instance.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cfg_we, cfg_ch, cfg_addr      config write strobe, channel, address
//   cfg_wdata                     config write data (CTRL uses [3:0])
//   count_o                       channel counts, ch i at [i*WIDTH +: WIDTH]
//   busy_o, tc_o, match_o, pwm_o  per-channel status/pulse outputs
// Build option: COUNTER_BANK_PWM_EN enables the per-channel PWM outputs.
import counter_bank_pkg::*;

module counter_bank #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 2,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [1:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_wdata,
  output logic [NCH*WIDTH-1:0] count_o,
  output logic [NCH-1:0]       busy_o,
  output logic [NCH-1:0]       tc_o,
  output logic [NCH-1:0]       match_o,
  output logic [NCH-1:0]       pwm_o
);

  logic [WIDTH-1:0] psc_q, presc_q;
  logic             presc_wr, tick;

  assign presc_wr = cfg_we && (cfg_addr == A_PRESC);
  // A PRESC write restarts the prescaler phase, so it never ticks that cycle.
  assign tick     = (psc_q == presc_q) && !presc_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q   <= '0;
      presc_q <= '0;
    end else if (presc_wr) begin
      psc_q   <= '0;
      presc_q <= cfg_wdata;
    end else if (psc_q == presc_q) begin
      psc_q   <= '0;
    end else begin
      psc_q   <= psc_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic sel;
    assign sel = cfg_we && (cfg_ch == CHW'(g)) && (cfg_addr != A_PRESC);

    counter_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .wr_ctrl_i   (sel && (cfg_addr == A_CTRL)),
      .wr_reload_i (sel && (cfg_addr == A_RELOAD)),
      .wr_cmp_i    (sel && (cfg_addr == A_CMP)),
      .wdata_i     (cfg_wdata),
      .count_o     (count_o[g*WIDTH +: WIDTH]),
      .busy_o      (busy_o[g]),
      .tc_o        (tc_o[g]),
      .match_o     (match_o[g]),
      .pwm_o       (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed table/sequence checks plus randomized config
// traffic compared every cycle against a behavioural model of the bank.
module tb_counter_bank;

  localparam int WIDTH = 8;
  localparam int NCH   = 2;
`ifdef COUNTER_BANK_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_we = 1'b0;
  logic [0:0]           cfg_ch = '0;
  logic [1:0]           cfg_addr = '0;
  logic [WIDTH-1:0]     cfg_wdata = '0;
  logic [NCH*WIDTH-1:0] count_o;
  logic [NCH-1:0]       busy_o, tc_o, match_o, pwm_o;

  int n_tests = 0;
  int n_fail  = 0;

  counter_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .count_o(count_o),
    .busy_o(busy_o), .tc_o(tc_o), .match_o(match_o), .pwm_o(pwm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt[NCH], m_rel[NCH], m_cmp[NCH], m_dir[NCH], m_mode[NCH];
  bit m_run[NCH], m_tc[NCH], m_match[NCH];
  int m_psc, m_presc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_psc = 0; m_presc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_rel[c] = 0; m_cmp[c] = 0; m_dir[c] = 0; m_mode[c] = 0;
        m_run[c] = 0; m_tc[c] = 0; m_match[c] = 0;
      end
    end else begin
      bit presc_wr, tick;
      presc_wr = cfg_we && cfg_addr == 2'd3;
      tick = !presc_wr && (m_psc == m_presc);
      if (presc_wr) begin m_presc = int'(cfg_wdata); m_psc = 0; end
      else if (tick) m_psc = 0;
      else m_psc = m_psc + 1;
      for (int c = 0; c < NCH; c++) begin
        bit wr;
        int old, tgt, st;
        wr = cfg_we && cfg_addr != 2'd3 && int'(cfg_ch) == c;
        m_tc[c] = 0; m_match[c] = 0;
        old = m_cnt[c];
        tgt = m_dir[c] ? 0 : m_rel[c];
        st  = m_dir[c] ? m_rel[c] : 0;
        if (wr) begin
          case (cfg_addr)
            2'd1: m_rel[c] = int'(cfg_wdata);
            2'd2: m_cmp[c] = int'(cfg_wdata);
            default: begin
              m_dir[c]  = int'(cfg_wdata[1]);
              m_mode[c] = int'(cfg_wdata[3:2]);
              m_run[c]  = cfg_wdata[0];
              if (cfg_wdata[0]) begin
                m_cnt[c]   = m_dir[c] ? m_rel[c] : 0;
                m_tc[c]    = (m_rel[c] == 0);
                m_match[c] = (m_cnt[c] == m_cmp[c]);
              end
            end
          endcase
        end else if (tick && m_run[c]) begin
          if (m_dir[c] ? (m_cnt[c] == 0) : (m_cnt[c] >= m_rel[c])) begin
            if (m_mode[c] == 1) m_cnt[c] = tgt;
            else if (m_mode[c] == 2) m_run[c] = 0;
            else begin m_cnt[c] = st; m_tc[c] = (st == tgt); end
          end else begin
            m_cnt[c] = m_dir[c] ? m_cnt[c] - 1 : m_cnt[c] + 1;
            m_tc[c]  = (m_cnt[c] == tgt);
          end
          m_match[c] = (m_cnt[c] != old) && (m_cnt[c] == m_cmp[c]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [NCH*WIDTH-1:0] ec;
      logic [NCH-1:0] eb, et, em, ep;
      for (int c = 0; c < NCH; c++) begin
        ec[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
        eb[c] = m_run[c];
        et[c] = m_tc[c];
        em[c] = m_match[c];
        ep[c] = PWM && m_run[c] && (m_cnt[c] < m_cmp[c]);
      end
      chk("model", 32'({count_o, busy_o, tc_o, match_o, pwm_o}), 32'({ec, eb, et, em, ep}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int ch, input int addr, input int data);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_addr = 2'(addr); cfg_wdata = WIDTH'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int cnt(input int ch);
    return int'(count_o[ch*WIDTH +: WIDTH]);
  endfunction

  typedef struct {
    logic       we;
    int         ch;
    int         addr;
    int         wd;
    int         e_cnt;
    logic       e_tc;
    logic       e_busy;
  } vec_t;

  vec_t tv[11];

  initial begin
    int ntc, nchg, exp_v, last_chg, prev, nmatch, npwm;
    int e3_cnt[5];
    bit e3_busy[5], e3_tc[5];

    #22 rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: up-WRAP, RELOAD=5, tick every clock
    tv[0]  = '{1'b1, 0, 3, 0, 0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 0, 1, 5, 0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 0, 0, 1, 0, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 0, 0, 0, 1, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 0, 0, 0, 2, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 0, 0, 0, 3, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 0, 0, 0, 4, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 0, 0, 0, 5, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 0, 0, 0, 1, 1'b0, 1'b1};
    tv[10] = '{1'b0, 0, 0, 0, 2, 1'b0, 1'b1};
    chk("reset_outputs", 32'({count_o, busy_o, tc_o, match_o, pwm_o}), 32'd0);
    for (int i = 0; i < 11; i++) begin
      cfg_we = tv[i].we; cfg_ch = 1'(tv[i].ch); cfg_addr = 2'(tv[i].addr);
      cfg_wdata = WIDTH'(tv[i].wd);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk($sformatf("t1_cnt[%0d]", i), 32'(cnt(0)), 32'(tv[i].e_cnt));
      chk($sformatf("t1_tc[%0d]", i), 32'(tc_o[0]), 32'(tv[i].e_tc));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy_o[0]), 32'(tv[i].e_busy));
    end

    // Test 2: PRESC=3, ch1 down-SAT RELOAD=4
    wr(0, 3, 3);
    wr(1, 1, 4);
    wr(1, 0, 4'b0111);
    chk("t2_start", 32'(cnt(1)), 32'd4);
    ntc = 0; nchg = 0; exp_v = 4; last_chg = 0; prev = 4;
    for (int i = 1; i <= 30; i++) begin
      idle(1);
      if (tc_o[1]) ntc++;
      if (cnt(1) != prev) begin
        nchg++;
        exp_v--;
        chk("t2_step_val", 32'(cnt(1)), 32'(exp_v));
        if (nchg > 1) chk("t2_step_gap", 32'(i - last_chg), 32'd4);
        last_chg = i;
        prev = cnt(1);
      end
    end
    chk("t2_changes", 32'(nchg), 32'd4);
    chk("t2_final", 32'(cnt(1)), 32'd0);
    chk("t2_tc_count", 32'(ntc), 32'd1);

    // Test 3: ch0 ONESHOT up RELOAD=3, then restart
    wr(0, 3, 0);
    wr(0, 1, 3);
    wr(0, 0, 4'b1001);
    chk("t3_start_cnt", 32'(cnt(0)), 32'd0);
    e3_cnt  = '{1, 2, 3, 3, 3};
    e3_busy = '{1, 1, 1, 0, 0};
    e3_tc   = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk($sformatf("t3_cnt[%0d]", i), 32'(cnt(0)), 32'(e3_cnt[i]));
      chk($sformatf("t3_busy[%0d]", i), 32'(busy_o[0]), 32'(e3_busy[i]));
      chk($sformatf("t3_tc[%0d]", i), 32'(tc_o[0]), 32'(e3_tc[i]));
    end
    wr(0, 0, 4'b1001);
    chk("t3_restart_cnt", 32'(cnt(0)), 32'd0);
    chk("t3_restart_busy", 32'(busy_o[0]), 32'd1);

    // Test 4: CMP=2, up-WRAP RELOAD=7
    wr(0, 2, 2);
    wr(0, 1, 7);
    wr(0, 0, 4'b0001);
    nmatch = 0; npwm = 0;
    for (int i = 0; i < 16; i++) begin
      if (match_o[0]) nmatch++;
      if (pwm_o[0]) npwm++;
      idle(1);
    end
    chk("t4_match_count", 32'(nmatch), 32'd2);
    chk("t4_pwm_count", 32'(npwm), PWM ? 32'd4 : 32'd0);

    // Test 5: config write in a tick cycle, freeze with en=0
    wr(0, 1, 9);
    wr(1, 1, 9);
    wr(1, 0, 1);
    chk("t5_ch1_start", 32'(cnt(1)), 32'd0);
    wr(0, 0, 1);
    chk("t5_ch0_start", 32'(cnt(0)), 32'd0);
    chk("t5_ch1_adv", 32'(cnt(1)), 32'd1);
    idle(3);
    chk("t5_ch0_run", 32'(cnt(0)), 32'd3);
    chk("t5_ch1_run", 32'(cnt(1)), 32'd4);
    wr(0, 0, 1);
    chk("t5_ch0_restart", 32'(cnt(0)), 32'd0);
    chk("t5_ch1_ticks", 32'(cnt(1)), 32'd5);
    idle(2);
    wr(0, 0, 0);
    chk("t5_ch0_freeze", 32'(cnt(0)), 32'd2);
    chk("t5_ch0_idle", 32'(busy_o[0]), 32'd0);
    chk("t5_ch1_after", 32'(cnt(1)), 32'd8);
    idle(3);
    chk("t5_ch0_held", 32'(cnt(0)), 32'd2);
    chk("t5_ch1_wrap", 32'(cnt(1)), 32'd1);
    wr(1, 2, 5);
    chk("t5_ch1_skip", 32'(cnt(1)), 32'd1);

    // Test 6: async reset between edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_async_rst", 32'({count_o, busy_o, tc_o, match_o, pwm_o}), 32'd0);
    #3 rst = 1'b0;
    idle(4);
    chk("t6_stay_idle", 32'({count_o, busy_o}), 32'd0);

    // RELOAD=0: WRAP pulses tc every tick, SAT only on start
    wr(0, 0, 4'b0001);
    chk("t7_wrap_tc0", 32'(tc_o[0]), 32'd1);
    wr(1, 0, 4'b0101);
    chk("t7_wrap_tc1", 32'(tc_o[0]), 32'd1);
    chk("t7_sat_start_tc", 32'(tc_o[1]), 32'd1);
    idle(1);
    chk("t7_wrap_tc2", 32'(tc_o[0]), 32'd1);
    chk("t7_sat_hold_tc", 32'(tc_o[1]), 32'd0);

    // Randomized traffic; the model checker compares every cycle
    for (int i = 0; i < 1500; i++) begin
      int a;
      a = $urandom_range(0, 3);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_addr  = 2'(a);
      case (a)
        0: cfg_wdata = WIDTH'($urandom_range(0, 15));
        3: cfg_wdata = WIDTH'($urandom_range(0, 2));
        default: cfg_wdata = WIDTH'($urandom_range(0, 12));
      endcase
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
